// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an asynchronous pin input
module uart_rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with valid/ready byte output
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rxd,
   output logic [UART_DATA_BITS-1:0] dout,
   output logic                      valid,
   input  logic                      ready,
   output logic                      busy,
   output logic                      framing_err,
   output logic                      overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic                      parity_err
`endif
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

   logic                      rxs;
   uart_rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [2:0]                idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] dout_q, dout_d;
   logic                      armed_q, armed_d;
   logic                      valid_q, valid_d;
   logic                      ferr_q, ferr_d;
   logic                      ovr_q, ovr_d;
   logic                      par_bad_q, par_bad_d;
   logic                      perr_q, perr_d;
   logic                      cnt_last;
   logic                      done;

   uart_rx_sync #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk_i   (clk),
      .reset_i (reset),
      .d_i     (rxd),
      .q_o     (rxs)
   );

   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      dout_d    = dout_q;
      armed_d   = armed_q;
      valid_d   = valid_q;
      par_bad_d = par_bad_q;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      perr_d    = 1'b0;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            if (rxs) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d   = START;
               cnt_d     = '0;
               idx_d     = '0;
               par_bad_d = 1'b0;
            end
         end
         START: begin
            // Re-check at mid start bit; a high line here was only a glitch.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               state_d = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            if (cnt_last) begin
               shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
               idx_d   = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            if (cnt_last) begin
               par_bad_d = rxs ^ (^shift_q);
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            if (cnt_last) begin
               state_d = IDLE;
               if (!rxs) begin
                  // Disarm so a break condition cannot look like a new start bit.
                  ferr_d  = 1'b1;
                  armed_d = 1'b0;
               end else if (par_bad_q) begin
                  perr_d = 1'b1;
               end else begin
                  done = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (done) begin
         if (!valid_q || ready) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         dout_q    <= '0;
         armed_q   <= 1'b0;
         valid_q   <= 1'b0;
         par_bad_q <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         dout_q    <= dout_d;
         armed_q   <= armed_d;
         valid_q   <= valid_d;
         par_bad_q <= par_bad_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
         perr_q    <= perr_d;
      end
   end

   assign dout        = dout_q;
   assign valid       = valid_q;
   assign busy        = (state_q != IDLE);
   assign framing_err = ferr_q;
   assign overrun     = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = perr_q;
`endif

endmodule
